gru_seq_driver: RTL and testbench
=================================

Name: gru_seq_driver

Overview:
- Synchronous sequencer that drives the combinational gru_lstm_cell over a multi-step input sequence.
- Holds the nine cell weights/biases in a register bank loaded over a config port.
- Accepts X samples on a valid/ready stream and feeds the cell output back as h_in each step.
- Emits every hidden state on a valid/ready output stream: the hardware counterpart of the cell's stimulus/observer bench.

Parameters:
- DATA_WIDTH, 8: width of X, h and every weight/bias; signed fixed point.
- FRACT_WIDTH, 5: fractional bits. Carried to the cell only; the driver does no arithmetic on data.
- LEN_WIDTH, 8: width of the sequence-length and step counters.
- CELL_LAT, 2: settle cycles allowed for the combinational cell after its inputs change. Legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_we  in  1  weight-bank write strobe
- cfg_addr  in  4  bank index: 0 Wz, 1 Wr, 2 Wh, 3 Uz, 4 Ur, 5 Uh, 6 bz, 7 br, 8 bh
- cfg_data  in  DATA_WIDTH  write data
- start  in  1  one-cycle start pulse
- seq_len  in  LEN_WIDTH  number of steps, sampled at start
- h_init  in  DATA_WIDTH  initial hidden state, sampled at start
- busy  out  1  high from accepted start until the last h handshake
- done  out  1  one-cycle pulse at sequence end
- x_valid / x_ready  in / out  1 / 1  input sample handshake
- x_data  in  DATA_WIDTH  input sample
- h_valid / h_ready  out / in  1 / 1  hidden-state output handshake
- h_data  out  DATA_WIDTH  hidden state of the current step
- h_last  out  1  qualifies h_data as the final step
- cell_X, cell_h_in  out  DATA_WIDTH each  cell inputs, registered
- cell_Wz, cell_Wr, cell_Wh, cell_Uz, cell_Ur, cell_Uh, cell_bz, cell_br, cell_bh  out  DATA_WIDTH each  direct bank register outputs
- cell_h_out  in  DATA_WIDTH  cell result

Behaviour:
- Reset (rst_n low at a clock edge, including mid-sequence):
  - all outputs, bank registers, counters and the h register go to 0; state goes to IDLE.
  - Any in-flight sequence is abandoned; no done pulse is generated.
- Config writes:
  - Take effect the cycle after cfg_we, and only while busy=0.
  - Writes while busy=1, or with cfg_addr>8, are silently dropped.
- FSM states: IDLE, WAIT_X, SETTLE, EMIT.
- IDLE:
  - start with seq_len!=0: latch seq_len, load h_reg=h_init, step=0, busy=1, go to WAIT_X.
  - start with seq_len==0: pulse done next cycle, busy stays 0, no output.
  - start while busy=1 is ignored.
- WAIT_X:
  - x_ready=1.
  - On x_valid&x_ready: cell_X<=x_data, cell_h_in<=h_reg, settle counter=CELL_LAT, go to SETTLE.
  - x_ready is 0 in every other state.
- SETTLE: decrement the counter each cycle. At 1, capture h_reg<=cell_h_out, go to EMIT.
- EMIT:
  - h_valid=1, h_data=h_reg, h_last=(step==len-1).
  - h_data, h_valid and h_last are held stable while h_ready=0.
  - On the handshake:
    - non-final step: step++, go to WAIT_X.
    - final step: busy<=0 and done pulses for 1 cycle in the cycle after the handshake; go to IDLE.
- Latency: first h_valid rises exactly CELL_LAT+1 cycles after the X handshake cycle.
- Throughput: with x_valid and h_ready held high, one step takes CELL_LAT+2 cycles.
- h_reg persists after done; cell_h_in keeps its last value in IDLE.
- Step counter never wraps: seq_len max is 2^LEN_WIDTH-1.

Decomposition:
- Shared package gru_pkg:
  - DATA_WIDTH/FRACT_WIDTH defaults.
  - Bank index constants IDX_WZ..IDX_BH and NUM_WEIGHTS=9.
  - FSM state encoding.
- One sub-module: gru_weight_bank (9-entry register bank with write enable, busy gate and address decode).
- The cell is instantiated at top level, not inside the driver.

Test Plan:
- Reset then config: write 0x20 to all 9 addresses, then write addr 9 -> bank holds 0x20 everywhere; addr 9 write has no effect.
- seq_len=3, h_init=0, X=0x10,0x08,0xF0, h_ready=1, CELL_LAT=2:
  - three h_valid beats, each 3 cycles after its X handshake, each equal to the model cell output.
  - cell_h_in chains the previous output; h_last on beat 3 only; done 1 cycle after beat 3.
- Output backpressure: h_ready=0 for 5 cycles in EMIT -> h_data stable, x_ready=0 throughout, no step lost.
- Config write attempted mid-sequence (busy=1) -> ignored; bank value unchanged after done.
- Edge starts:
  - start with seq_len=0 -> done pulse, busy never rises, h_valid never rises.
  - second start while busy -> ignored.
- Reset during SETTLE of step 2 -> all outputs 0 next cycle, no done; a fresh start with seq_len=1 then works normally.

Source files
------------

// File: rtl/gru_pkg.sv
// gru_pkg: shared widths, weight-bank indices and sequencer state encoding
package gru_pkg;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_FRACT_WIDTH = 5;

    localparam logic [3:0] IDX_WZ      = 4'd0;
    localparam logic [3:0] IDX_WR      = 4'd1;
    localparam logic [3:0] IDX_WH      = 4'd2;
    localparam logic [3:0] IDX_UZ      = 4'd3;
    localparam logic [3:0] IDX_UR      = 4'd4;
    localparam logic [3:0] IDX_UH      = 4'd5;
    localparam logic [3:0] IDX_BZ      = 4'd6;
    localparam logic [3:0] IDX_BR      = 4'd7;
    localparam logic [3:0] IDX_BH      = 4'd8;
    localparam logic [3:0] NUM_WEIGHTS = 4'd9;

    typedef enum logic [1:0] {IDLE, WAIT_X, SETTLE, EMIT} state_e;
endpackage

// File: rtl/gru_weight_bank.sv
// gru_weight_bank: nine weight/bias registers, writable only while the sequencer is idle
module gru_weight_bank
    import gru_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [3:0]            addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  busy,
    output logic [DATA_WIDTH-1:0] w [NUM_WEIGHTS]
);
    logic [DATA_WIDTH-1:0] w_q [NUM_WEIGHTS];
    logic [DATA_WIDTH-1:0] w_d [NUM_WEIGHTS];

    always_comb begin
        w_d = w_q;
        if (we && !busy && addr < NUM_WEIGHTS) w_d[addr] = data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) w_q <= '{default: '0};
        else        w_q <= w_d;
    end

    assign w = w_q;
endmodule

// File: rtl/gru_seq_driver.sv
// gru_seq_driver: steps the combinational GRU cell over an X stream, feeding h back each step
module gru_seq_driver
    import gru_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
    parameter int LEN_WIDTH   = 8,
    parameter int CELL_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  seq_len,
    input  logic [DATA_WIDTH-1:0] h_init,
    output logic                  busy,
    output logic                  done,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic                  h_valid,
    input  logic                  h_ready,
    output logic [DATA_WIDTH-1:0] h_data,
    output logic                  h_last,
    output logic [DATA_WIDTH-1:0] cell_X,
    output logic [DATA_WIDTH-1:0] cell_h_in,
    output logic [DATA_WIDTH-1:0] cell_Wz,
    output logic [DATA_WIDTH-1:0] cell_Wr,
    output logic [DATA_WIDTH-1:0] cell_Wh,
    output logic [DATA_WIDTH-1:0] cell_Uz,
    output logic [DATA_WIDTH-1:0] cell_Ur,
    output logic [DATA_WIDTH-1:0] cell_Uh,
    output logic [DATA_WIDTH-1:0] cell_bz,
    output logic [DATA_WIDTH-1:0] cell_br,
    output logic [DATA_WIDTH-1:0] cell_bh,
    input  logic [DATA_WIDTH-1:0] cell_h_out
);
    if (CELL_LAT < 1 || CELL_LAT > 15 || FRACT_WIDTH < 0 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_params
        $error("gru_seq_driver: CELL_LAT must be 1..15 and FRACT_WIDTH below DATA_WIDTH");
    end

    localparam logic [3:0] LAT = 4'(CELL_LAT);

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  step_q, step_d;
    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] hin_q, hin_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  last;
    logic [DATA_WIDTH-1:0] w [NUM_WEIGHTS];

    gru_weight_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (cfg_we),
        .addr (cfg_addr),
        .data (cfg_data),
        .busy (busy_q),
        .w    (w)
    );

    assign last = step_q == len_q - LEN_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        step_d  = step_q;
        h_d     = h_q;
        x_d     = x_q;
        hin_d   = hin_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (seq_len == '0) begin
                    done_d = 1'b1;
                end else begin
                    len_d   = seq_len;
                    h_d     = h_init;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = WAIT_X;
                end
            end
            WAIT_X: if (x_valid) begin
                x_d     = x_data;
                hin_d   = h_q;
                cnt_d   = LAT;
                state_d = SETTLE;
            end
            // the cell output is trusted only on the last settle cycle
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    h_d     = cell_h_out;
                    state_d = EMIT;
                end
            end
            EMIT: if (h_ready) begin
                if (last) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    step_d  = step_q + LEN_WIDTH'(1);
                    state_d = WAIT_X;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            step_q  <= '0;
            h_q     <= '0;
            x_q     <= '0;
            hin_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            step_q  <= step_d;
            h_q     <= h_d;
            x_q     <= x_d;
            hin_q   <= hin_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign x_ready   = state_q == WAIT_X;
    assign h_valid   = state_q == EMIT;
    assign h_last    = h_valid && last;
    assign h_data    = h_q;
    assign cell_X    = x_q;
    assign cell_h_in = hin_q;
    assign cell_Wz   = w[IDX_WZ];
    assign cell_Wr   = w[IDX_WR];
    assign cell_Wh   = w[IDX_WH];
    assign cell_Uz   = w[IDX_UZ];
    assign cell_Ur   = w[IDX_UR];
    assign cell_Uh   = w[IDX_UH];
    assign cell_bz   = w[IDX_BZ];
    assign cell_br   = w[IDX_BR];
    assign cell_bh   = w[IDX_BH];
endmodule

// File: tb/tb_gru_seq_driver.sv
// tb_gru_seq_driver: stand-in cell, sequence-level reference model and directed scenarios
module tb_gru_seq_driver;
    localparam int LAT = 2;
    localparam int FW  = 5;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       start = 1'b0;
    logic [7:0] seq_len = '0, h_init = '0;
    logic       x_valid = 1'b0, h_ready = 1'b0;
    logic [7:0] x_data = '0;
    logic       busy, done, x_ready, h_valid, h_last;
    logic [7:0] h_data, cell_X, cell_h_in, cell_h_out;
    logic [7:0] cell_Wz, cell_Wr, cell_Wh, cell_Uz, cell_Ur, cell_Uh, cell_bz, cell_br, cell_bh;
    logic [7:0] bank [9];

    int checks = 0, failures = 0, cyc = 0;

    gru_seq_driver #(.DATA_WIDTH(8), .FRACT_WIDTH(FW), .LEN_WIDTH(8), .CELL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .seq_len(seq_len), .h_init(h_init), .busy(busy), .done(done),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data), .h_last(h_last),
        .cell_X(cell_X), .cell_h_in(cell_h_in),
        .cell_Wz(cell_Wz), .cell_Wr(cell_Wr), .cell_Wh(cell_Wh),
        .cell_Uz(cell_Uz), .cell_Ur(cell_Ur), .cell_Uh(cell_Uh),
        .cell_bz(cell_bz), .cell_br(cell_br), .cell_bh(cell_bh),
        .cell_h_out(cell_h_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        bank[0] = cell_Wz; bank[1] = cell_Wr; bank[2] = cell_Wh;
        bank[3] = cell_Uz; bank[4] = cell_Ur; bank[5] = cell_Uh;
        bank[6] = cell_bz; bank[7] = cell_br; bank[8] = cell_bh;
    end

    // stand-in cell: h' = sat(Wz*x + Uz*h + bz) in Q3.5
    function automatic logic [7:0] cell_f(input logic [7:0] x, h, wz, uz, bz);
        int s;
        s = ((int'($signed(wz)) * int'($signed(x))) >>> FW) +
            ((int'($signed(uz)) * int'($signed(h))) >>> FW) + int'($signed(bz));
        s = s > 127 ? 127 : (s < -128 ? -128 : s);
        return 8'(s);
    endfunction

    // output is garbage for the first cycle after the inputs move
    logic [7:0] prev_x = '0, prev_h = '0;
    always @(posedge clk) begin
        prev_x <= cell_X;
        prev_h <= cell_h_in;
    end
    assign cell_h_out = (cell_X == prev_x && cell_h_in == prev_h) ?
                        cell_f(cell_X, cell_h_in, cell_Wz, cell_Uz, cell_bz) : 8'h55;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    // sequence-level reference model
    logic       m_busy = 1'b0, m_out = 1'b0, m_done = 1'b0;
    logic [7:0] m_h = '0, m_cx = '0, m_chin = '0;
    logic [7:0] m_w [9] = '{default: '0};
    int         m_len = 0, m_step = 0, m_tx = 0;
    logic [7:0] mbeats[$];
    int         mlat[$];

    always @(posedge clk) begin
        logic hv, dn;
        hv = m_out && cyc >= m_tx + LAT + 1;
        dn = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_out = 1'b0; m_h = '0; m_cx = '0; m_chin = '0;
            m_len = 0; m_step = 0; m_tx = 0;
            for (int i = 0; i < 9; i++) m_w[i] = '0;
        end else begin
            if (cfg_we && !m_busy && cfg_addr < 4'd9) m_w[cfg_addr] = cfg_data;
            if (!m_busy) begin
                if (start && seq_len == 8'd0) dn = 1'b1;
                else if (start) begin
                    m_busy = 1'b1; m_len = int'(seq_len); m_step = 0; m_h = h_init;
                end
            end else if (!m_out) begin
                if (x_valid) begin
                    m_cx = x_data; m_chin = m_h;
                    m_h = cell_f(x_data, m_h, m_w[0], m_w[3], m_w[6]);
                    m_out = 1'b1; m_tx = cyc;
                end
            end else if (hv && h_ready) begin
                mbeats.push_back(m_h);
                mlat.push_back(cyc - m_tx);
                if (m_step == m_len - 1) begin
                    m_busy = 1'b0; dn = 1'b1;
                end else m_step++;
                m_out = 1'b0;
            end
        end
        m_done = dn;
        cyc++;
    end

    always @(negedge clk) begin
        logic hv;
        hv = m_out && cyc >= m_tx + LAT + 1;
        chk("busy", 8'(busy), 8'(m_busy));
        chk("done", 8'(done), 8'(m_done));
        chk("x_ready", 8'(x_ready), 8'(m_busy && !m_out));
        chk("h_valid", 8'(h_valid), 8'(hv));
        if (hv) begin
            chk("h_data", h_data, m_h);
            chk("h_last", 8'(h_last), 8'(m_step == m_len - 1));
        end
        chk("cell_X", cell_X, m_cx);
        chk("cell_h_in", cell_h_in, m_chin);
        for (int i = 0; i < 9; i++) chk("bank", bank[i], m_w[i]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_seq(input logic [7:0] len, input logic [7:0] hi);
        start = 1'b1; seq_len = len; h_init = hi;
        tick();
        start = 1'b0;
    endtask

    task automatic send_x(input logic [7:0] v);
        int n = 0;
        x_valid = 1'b1; x_data = v;
        @(negedge clk);
        while (!x_ready && n < 50) begin @(negedge clk); n++; end
        chk("x_ready_wait", 8'(x_ready), 8'd1);
        tick();
        x_valid = 1'b0;
    endtask

    task automatic wait_h();
        int n = 0;
        @(negedge clk);
        while (!h_valid && n < 50) begin @(negedge clk); n++; end
        chk("h_valid_wait", 8'(h_valid), 8'd1);
    endtask

    logic [7:0] exp_b [9] = '{8'h30, 8'h58, 8'h68, 8'h34, 8'h7F, 8'h21, 8'h43, 8'h30, 8'h28};
    int         exp_l [9] = '{3, 3, 3, 8, 3, 3, 3, 3, 3};

    initial begin
        logic [7:0] hd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_h_valid", 8'(h_valid), 8'd0);
        chk("rst_h_data", h_data, 8'd0);
        chk("rst_cell_Wz", cell_Wz, 8'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) cfg(4'(i), 8'(i + 1));
        @(negedge clk);
        for (int i = 0; i < 9; i++) chk("cfg_distinct", bank[i], 8'(i + 1));
        tick();
        for (int i = 0; i < 9; i++) cfg(4'(i), 8'h20);
        cfg(4'd9, 8'h77);
        @(negedge clk);
        for (int i = 0; i < 9; i++) chk("cfg_all20", bank[i], 8'h20);
        tick();

        // three-step sequence, no backpressure
        h_ready = 1'b1;
        start_seq(8'd3, 8'h00);
        send_x(8'h10);
        send_x(8'h08);
        send_x(8'hF0);
        repeat (6) tick();

        // output backpressure with a config write attempted while busy
        h_ready = 1'b0;
        start_seq(8'd2, 8'h10);
        send_x(8'h04);
        wait_h();
        hd = h_data;
        cfg(4'd0, 8'h7F);
        repeat (5) begin
            @(negedge clk);
            chk("bp_h_data", h_data, hd);
            chk("bp_h_valid", 8'(h_valid), 8'd1);
            chk("bp_x_ready", 8'(x_ready), 8'd0);
        end
        h_ready = 1'b1;
        send_x(8'h70);
        repeat (6) tick();
        chk("cfg_dropped", cell_Wz, 8'h20);

        // zero-length start
        start_seq(8'd0, 8'h33);
        @(negedge clk);
        chk("len0_done", 8'(done), 8'd1);
        chk("len0_busy", 8'(busy), 8'd0);
        repeat (3) tick();

        // restart attempt while busy
        start_seq(8'd2, 8'h00);
        send_x(8'h01);
        start_seq(8'd5, 8'h40);
        send_x(8'h02);
        repeat (8) tick();

        // reset while settling step 2
        start_seq(8'd3, 8'h00);
        send_x(8'h10);
        send_x(8'h08);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_done", 8'(done), 8'd0);
        chk("mid_rst_h_valid", 8'(h_valid), 8'd0);
        chk("mid_rst_x_ready", 8'(x_ready), 8'd0);
        chk("mid_rst_h_data", h_data, 8'd0);
        chk("mid_rst_cell_X", cell_X, 8'd0);
        chk("mid_rst_cell_h_in", cell_h_in, 8'd0);
        chk("mid_rst_cell_Wz", cell_Wz, 8'd0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_done", 8'(done), 8'd0);
        end
        tick();
        cfg(4'd0, 8'h20);
        cfg(4'd3, 8'h20);
        cfg(4'd6, 8'h20);
        start_seq(8'd1, 8'h05);
        send_x(8'h03);
        wait_h();
        chk("fresh_h_data", h_data, 8'h28);
        chk("fresh_h_last", 8'(h_last), 8'd1);
        repeat (4) tick();

        chk("beat_count", 8'(mbeats.size()), 8'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < mbeats.size()) begin
                chk("model_beat", mbeats[i], exp_b[i]);
                chk("model_latency", 8'(mlat[i]), 8'(exp_l[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
